// File: rtl/demux_1to4_buffered_pkg.sv
// Shared definitions for the 1-to-4 buffered word router.
package demux_1to4_buffered_pkg;

  // Datapath word width and destination index width.
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int SEL_WIDTH          = 2;
  localparam int NUM_DEST           = 1 << SEL_WIDTH;

  // Entries per destination FIFO (power of two, at least 2).
  localparam int DEFAULT_DEPTH      = 2;

  // One-hot decode of a destination index.
  function automatic logic [NUM_DEST-1:0] dest_decode(input logic [SEL_WIDTH-1:0] sel);
    logic [NUM_DEST-1:0] hot;
    hot      = '0;
    hot[sel] = 1'b1;
    return hot;
  endfunction

endpackage

// File: rtl/demux_1to4_buffered_fifo.sv
// demux_fifo: synchronous FIFO with push/pop, full/empty flags and a head word.
// Push is ignored when full and pop is ignored when empty, so no word can be
// overwritten or popped twice regardless of what the caller drives.
module demux_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic                  push_ok;
  logic                  pop_ok;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Next pointers, occupancy and storage; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state register; reset empties the FIFO and drops any handshake.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/demux_1to4_buffered.sv
// demux_1to4_buffered: routes one word per cycle into one of four FIFOs chosen
// by select; each FIFO is drained by its own consumer.
//
// Handshakes: a transfer happens at a rising edge where valid && ready. The
// input side's in_ready depends only on select and registered occupancy (never
// on any out_ready), so a full FIFO refuses a push even if it pops that cycle.
// The producer holds data_input/select stable while in_valid && !in_ready.
// Each output presents its head word while out_valid_k and holds it until popped.
module demux_1to4_buffered
  import demux_1to4_buffered_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] data_input,
  input  logic [SEL_WIDTH-1:0]  select,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] data_output_0,
  output logic [DATA_WIDTH-1:0] data_output_1,
  output logic [DATA_WIDTH-1:0] data_output_2,
  output logic [DATA_WIDTH-1:0] data_output_3,
  output logic                  out_valid_0,
  output logic                  out_valid_1,
  output logic                  out_valid_2,
  output logic                  out_valid_3,
  input  logic                  out_ready_0,
  input  logic                  out_ready_1,
  input  logic                  out_ready_2,
  input  logic                  out_ready_3
);

  logic [NUM_DEST-1:0]   push_v;
  logic [NUM_DEST-1:0]   pop_v;
  logic [NUM_DEST-1:0]   full_v;
  logic [NUM_DEST-1:0]   empty_v;
  logic [DATA_WIDTH-1:0] head_v   [NUM_DEST];
  logic [DATA_WIDTH-1:0] out_data [NUM_DEST];

  assign pop_v = {out_ready_3, out_ready_2, out_ready_1, out_ready_0};

  // Select decode and ready mux: only the addressed FIFO sees the push.
  always_comb begin
    in_ready = !full_v[select];
    push_v   = (in_valid && !full_v[select]) ? dest_decode(select) : '0;
  end

  for (genvar k = 0; k < NUM_DEST; k++) begin : g_dest
    demux_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push_v[k]),
      .push_data (data_input),
      .pop       (pop_v[k]),
      .full      (full_v[k]),
      .empty     (empty_v[k]),
      .head      (head_v[k])
    );
  end

  // Outputs read as zero while their FIFO is empty.
  always_comb begin
    for (int k = 0; k < NUM_DEST; k++) begin
      out_data[k] = empty_v[k] ? '0 : head_v[k];
    end
  end

  assign data_output_0 = out_data[0];
  assign data_output_1 = out_data[1];
  assign data_output_2 = out_data[2];
  assign data_output_3 = out_data[3];
  assign out_valid_0   = !empty_v[0];
  assign out_valid_1   = !empty_v[1];
  assign out_valid_2   = !empty_v[2];
  assign out_valid_3   = !empty_v[3];

endmodule

// File: tb/tb_demux_1to4_buffered.sv
// Bench for demux_1to4_buffered: directed scenarios plus random traffic, with
// a per-destination queue model and a negedge monitor doing the comparisons.
module tb_demux_1to4_buffered;

  localparam int DW      = 32;
  localparam int DEPTH   = 2;
  localparam int TIMEOUT = 50;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic [DW-1:0] data_input;
  logic [1:0]    select;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    out_ready_v;
  logic [3:0]    out_valid_v;
  logic [DW-1:0] dout [4];

  demux_1to4_buffered #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .data_input    (data_input),
    .select        (select),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .data_output_0 (dout[0]),
    .data_output_1 (dout[1]),
    .data_output_2 (dout[2]),
    .data_output_3 (dout[3]),
    .out_valid_0   (out_valid_v[0]),
    .out_valid_1   (out_valid_v[1]),
    .out_valid_2   (out_valid_v[2]),
    .out_valid_3   (out_valid_v[3]),
    .out_ready_0   (out_ready_v[0]),
    .out_ready_1   (out_ready_v[1]),
    .out_ready_2   (out_ready_v[2]),
    .out_ready_3   (out_ready_v[3])
  );

  // Scoreboard: one expected queue per destination; occupancy is its size.
  logic [DW-1:0] exp_q [4][$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: compare the DUT against the model, then retire model pops.
  always @(negedge clk) begin
    logic          ev;
    logic [DW-1:0] ed;
    if (reset_n === 1'b1) begin
      for (int k = 0; k < 4; k++) begin
        ev = (exp_q[k].size() != 0);
        ed = ev ? exp_q[k][0] : '0;
        check($sformatf("out_valid_%0d", k), 32'(out_valid_v[k]), 32'(ev));
        check($sformatf("data_output_%0d", k), dout[k], ed);
      end
      if (in_valid === 1'b1)
        check("in_ready", 32'(in_ready), 32'(exp_q[select].size() < DEPTH));
      for (int k = 0; k < 4; k++) begin
        if (exp_q[k].size() != 0 && out_ready_v[k] === 1'b1) void'(exp_q[k].pop_front());
      end
    end
  end

  // Driver tasks: each starts and ends 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    for (int k = 0; k < 4; k++) exp_q[k].delete();
    repeat (n) tick();
    reset_n = 1'b1;
  endtask

  task automatic push_word(input logic [1:0] sel, input logic [DW-1:0] d,
                           input bit rand_ready, output int waits);
    bit done;
    waits      = 0;
    done       = 1'b0;
    in_valid   = 1'b1;
    select     = sel;
    data_input = d;
    while (!done) begin
      #6;
      if (in_ready === 1'b1) begin
        exp_q[sel].push_back(d);
        done = 1'b1;
      end else if (waits >= TIMEOUT) begin
        n_cmp++;
        n_err++;
        $display("FAIL push_timeout: in_ready=%b for sel %0d, required 1 within %0d cycles", in_ready, sel, TIMEOUT);
        done = 1'b1;
      end else begin
        waits++;
      end
      tick();
      if (!done && rand_ready) out_ready_v = 4'($urandom);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, required finish before 300000");
    $fatal(1);
  end

  initial begin
    int w;
    reset_n     = 1'b0;
    in_valid    = 1'b0;
    select      = 2'd0;
    data_input  = '0;
    out_ready_v = 4'h0;

    // Reset then idle
    do_reset(2);
    #5;
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_out_valid", 32'(out_valid_v), 32'd0);
    for (int k = 0; k < 4; k++) check($sformatf("idle_data_%0d", k), dout[k], 32'd0);
    tick();

    // Basic route: visible exactly one cycle after the push, only on output 2
    push_word(2'd2, 32'hDEADBEEF, 1'b0, w);
    check("basic_wait", 32'(w), 32'd0);
    #5;
    check("basic_valid", 32'(out_valid_v), 32'h4);
    check("basic_data", dout[2], 32'hDEADBEEF);
    tick();
    out_ready_v = 4'hF;
    repeat (2) tick();

    // Fill and backpressure on FIFO 1
    out_ready_v = 4'h0;
    push_word(2'd1, 32'h1, 1'b0, w);
    push_word(2'd1, 32'h2, 1'b0, w);
    in_valid   = 1'b1;
    select     = 2'd1;
    data_input = 32'h3;
    #5;
    check("full_in_ready", 32'(in_ready), 32'd0);
    tick();
    out_ready_v[1] = 1'b1;
    push_word(2'd1, 32'h3, 1'b0, w);
    check("refill_wait", 32'(w), 32'd1);
    repeat (3) tick();

    // Full FIFO 0 with a pop in the same cycle as the offered push
    out_ready_v = 4'h0;
    push_word(2'd0, 32'hA0, 1'b0, w);
    push_word(2'd0, 32'hA1, 1'b0, w);
    out_ready_v[0] = 1'b1;
    push_word(2'd0, 32'hAA, 1'b0, w);
    check("full_pop_wait", 32'(w), 32'd1);
    repeat (4) tick();

    // Concurrent streaming across all destinations
    out_ready_v = 4'hF;
    for (int i = 0; i < 16; i++) begin
      push_word(2'(i % 4), 32'(i), 1'b0, w);
      check("stream_wait", 32'(w), 32'd0);
    end
    repeat (3) tick();

    // Reset mid-operation discards FIFO 3 contents
    out_ready_v = 4'h0;
    push_word(2'd3, 32'h33, 1'b0, w);
    push_word(2'd3, 32'h34, 1'b0, w);
    do_reset(1);
    #5;
    check("reset_mid_valid", 32'(out_valid_v[3]), 32'd0);
    check("reset_mid_data", dout[3], 32'd0);
    tick();
    push_word(2'd3, 32'h55, 1'b0, w);
    tick();
    out_ready_v[3] = 1'b1;
    repeat (3) tick();

    // Random traffic with random consumer stalls
    repeat (400) begin
      out_ready_v = 4'($urandom);
      if ($urandom_range(0, 3) != 0)
        push_word(2'($urandom_range(0, 3)), $urandom, 1'b1, w);
      else
        tick();
    end

    // Drain and confirm nothing is left behind
    out_ready_v = 4'hF;
    repeat (6) tick();
    #5;
    check("drain_out_valid", 32'(out_valid_v), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
